// File: rtl/reg_write_arbiter.sv
// Request/grant arbiter for the shared register write bus: three masters, fixed priority,
// hold-until-release grant, stall watchdog and drop/timeout status.
module reg_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [2:0]  req,
  output logic [2:0]  gnt,
  input  logic [2:0]  m_wen,
  input  logic [2:0]  m_blk_wen,
  input  logic [2:0]  m_blk_wstart,
  input  logic [47:0] m_waddr,
  input  logic [95:0] m_wdata,
  output logic        reg_wen,
  output logic        blk_wen,
  output logic        blk_wstart,
  output logic [15:0] reg_waddr,
  output logic [31:0] reg_wdata,
  input  logic        status_clr,
  output logic [31:0] status
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [1:0]  OWNER_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [1:0]          owner, owner_nxt;
  logic [2:0]          gnt_nxt;
  logic [CNT_W-1:0]    wd_cnt, wd_nxt;
  logic [2:0]          blocked, blocked_nxt;
  logic [2:0]          timeout_err, terr_nxt;
  logic [7:0]          drop_count, drop_nxt;
  logic                reg_wen_nxt, blk_wen_nxt, blk_wstart_nxt;
  logic [ADDR_W-1:0]   waddr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;

  logic                sel_req, sel_wen, sel_blk_wen, sel_blk_wstart, sel_strobe;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [2:0]          eligible, any_strobe, gnt_active;
  logic                drop;

  // Current owner's request, strobes and payload
  always_comb begin
    sel_req        = 1'b0;
    sel_wen        = 1'b0;
    sel_blk_wen    = 1'b0;
    sel_blk_wstart = 1'b0;
    sel_addr       = '0;
    sel_data       = '0;
    for (int i = 0; i < 3; i++) begin
      if (owner == 2'(i)) begin
        sel_req        = req[i];
        sel_wen        = m_wen[i];
        sel_blk_wen    = m_blk_wen[i];
        sel_blk_wstart = m_blk_wstart[i];
        sel_addr       = m_waddr[ADDR_W*i +: ADDR_W];
        sel_data       = m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sel_strobe = sel_wen | sel_blk_wen | sel_blk_wstart;
  assign eligible   = req & ~blocked;
  assign any_strobe = m_wen | m_blk_wen | m_blk_wstart;
  assign gnt_active = (state == GRANT) ? gnt : 3'b000;
  assign drop       = |(any_strobe & ~gnt_active);

  // Next-state, bus forwarding and status bookkeeping
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    gnt_nxt        = gnt;
    wd_nxt         = wd_cnt;
    blocked_nxt    = blocked & req;
    terr_nxt       = timeout_err;
    drop_nxt       = drop_count;
    reg_wen_nxt    = 1'b0;
    blk_wen_nxt    = 1'b0;
    blk_wstart_nxt = 1'b0;
    waddr_nxt      = reg_waddr;
    wdata_nxt      = reg_wdata;

    case (state)
      IDLE: begin
        wd_nxt = '0;
        if (eligible[1]) begin
          state_nxt = GRANT; owner_nxt = 2'd1; gnt_nxt = 3'b010;
        end else if (eligible[0]) begin
          state_nxt = GRANT; owner_nxt = 2'd0; gnt_nxt = 3'b001;
        end else if (eligible[2]) begin
          state_nxt = GRANT; owner_nxt = 2'd2; gnt_nxt = 3'b100;
        end
      end
      GRANT: begin
        reg_wen_nxt    = sel_wen;
        blk_wen_nxt    = sel_blk_wen;
        blk_wstart_nxt = sel_blk_wstart;
        if (sel_strobe) begin
          waddr_nxt = sel_addr;
          wdata_nxt = sel_data;
        end
        wd_nxt = sel_strobe ? '0 : wd_cnt + CNT_W'(1);
        if (!sel_req) begin
          state_nxt = RELEASE; owner_nxt = OWNER_NONE; gnt_nxt = 3'b000; wd_nxt = '0;
        end else if (!sel_strobe && (wd_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) begin
          // Stalled owner: flag it and lock it out until it drops req
          terr_nxt    = timeout_err | gnt;
          blocked_nxt = blocked_nxt | gnt;
          state_nxt   = RELEASE; owner_nxt = OWNER_NONE; gnt_nxt = 3'b000; wd_nxt = '0;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        owner_nxt = OWNER_NONE;
        gnt_nxt   = 3'b000;
        wd_nxt    = '0;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWNER_NONE;
        gnt_nxt   = 3'b000;
      end
    endcase

    if (status_clr) begin
      drop_nxt = '0;
      terr_nxt = '0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_nxt = drop_count + 8'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWNER_NONE;
      gnt         <= '0;
      wd_cnt      <= '0;
      blocked     <= '0;
      timeout_err <= '0;
      drop_count  <= '0;
      reg_wen     <= 1'b0;
      blk_wen     <= 1'b0;
      blk_wstart  <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      gnt         <= gnt_nxt;
      wd_cnt      <= wd_nxt;
      blocked     <= blocked_nxt;
      timeout_err <= terr_nxt;
      drop_count  <= drop_nxt;
      reg_wen     <= reg_wen_nxt;
      blk_wen     <= blk_wen_nxt;
      blk_wstart  <= blk_wstart_nxt;
      reg_waddr   <= waddr_nxt;
      reg_wdata   <= wdata_nxt;
    end
  end

  assign status = {16'd0, drop_count, 1'b0, timeout_err, state, owner};

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector table, corner sequences,
// and randomized traffic compared against a cycle-level behavioural model.
module tb_reg_write_arbiter;

  localparam int TO = 4096;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [2:0]  req, gnt, m_wen, m_blk_wen, m_blk_wstart;
  logic [47:0] m_waddr;
  logic [95:0] m_wdata;
  logic        reg_wen, blk_wen, blk_wstart, status_clr;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata, status;

  reg_write_arbiter dut (
    .sysclk(sysclk), .reset(reset), .req(req), .gnt(gnt),
    .m_wen(m_wen), .m_blk_wen(m_blk_wen), .m_blk_wstart(m_blk_wstart),
    .m_waddr(m_waddr), .m_wdata(m_wdata),
    .reg_wen(reg_wen), .blk_wen(blk_wen), .blk_wstart(blk_wstart),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .status_clr(status_clr), .status(status)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=idle, 1=granted, 2=turnaround; owner -1 means nobody
  int         ph, own, quiet, drops;
  bit         lock [3];
  bit [2:0]   err;
  bit         e_wen, e_bwen, e_bws;
  bit [15:0]  e_addr;
  bit [31:0]  e_data;
  int         prio [3] = '{1, 0, 2};

  function automatic void model_reset();
    ph = 0; own = -1; quiet = 0; drops = 0; err = '0;
    foreach (lock[i]) lock[i] = 0;
    e_wen = 0; e_bwen = 0; e_bws = 0; e_addr = '0; e_data = '0;
  endfunction

  function automatic void model_step();
    int  holder, nph, newlock;
    bit  dropped, s;
    if (reset) begin
      model_reset();
      return;
    end
    holder  = (ph == 1) ? own : -1;
    dropped = 0;
    for (int i = 0; i < 3; i++)
      if (i != holder && (m_wen[i] || m_blk_wen[i] || m_blk_wstart[i])) dropped = 1;
    e_wen = 0; e_bwen = 0; e_bws = 0;
    nph = ph; newlock = -1;
    if (ph == 0) begin
      for (int k = 0; k < 3; k++)
        if (nph == 0 && req[prio[k]] && !lock[prio[k]]) begin
          own = prio[k]; nph = 1; quiet = 0;
        end
    end else if (ph == 1) begin
      e_wen = m_wen[own]; e_bwen = m_blk_wen[own]; e_bws = m_blk_wstart[own];
      s = e_wen || e_bwen || e_bws;
      if (s) begin
        e_addr = m_waddr[16*own +: 16];
        e_data = m_wdata[32*own +: 32];
      end
      quiet = s ? 0 : quiet + 1;
      if (!req[own]) begin
        nph = 2; own = -1;
      end else if (quiet == TO) begin
        err[own] = 1; newlock = own; nph = 2; own = -1;
      end
    end else begin
      nph = 0;
    end
    for (int i = 0; i < 3; i++) if (!req[i]) lock[i] = 0;
    if (newlock >= 0) lock[newlock] = 1;
    if (status_clr) begin
      drops = 0; err = '0;
    end else if (dropped && drops < 255) begin
      drops++;
    end
    ph = nph;
  endfunction

  function automatic logic [2:0] exp_gnt();
    logic [2:0] g;
    g = '0;
    if (ph == 1) g[own] = 1'b1;
    return g;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [1:0] o;
    o = (own < 0) ? 2'b11 : 2'(own);
    return {16'd0, 8'(drops), 1'b0, err, 2'(ph), o};
  endfunction

  task automatic step();
    @(posedge sysclk);
    model_step();
    #1;
    chk("model_gnt", 64'(gnt), 64'(exp_gnt()));
    chk("model_bus", 64'({reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata}),
                     64'({e_wen, e_bwen, e_bws, e_addr, e_data}));
    chk("model_status", 64'(status), 64'(exp_status()));
  endtask

  task automatic quiet_inputs();
    req = '0; m_wen = '0; m_blk_wen = '0; m_blk_wstart = '0; status_clr = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wen;
    logic [2:0]  e_gnt;
    logic        e_wen;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] e_status;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [2:0] g,
                              input logic ew, input logic held, input logic [31:0] st);
    vec_t v;
    v.req = r; v.wen = w; v.e_gnt = g; v.e_wen = ew;
    v.e_addr = held ? 16'h0003 : 16'h0000;
    v.e_data = held ? 32'hA5A5_0001 : 32'h0;
    v.e_status = st;
    return v;
  endfunction

  vec_t vt [22];
  int   cnt;
  bit   saw;

  initial begin
    m_waddr = '0; m_wdata = '0;
    quiet_inputs();
    model_reset();
    reset = 1'b1;
    step();
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_bus", 64'({reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata}), 64'h0);
    chk("reset_status", 64'(status), 64'h3);
    reset = 1'b0;

    // Single write, priority ordering with turnaround, no preemption
    vt[0]  = mk(3'b001, 3'b000, 3'b001, 0, 0, 32'h4);
    vt[1]  = mk(3'b001, 3'b001, 3'b001, 1, 1, 32'h4);
    vt[2]  = mk(3'b001, 3'b000, 3'b001, 0, 1, 32'h4);
    vt[3]  = mk(3'b000, 3'b000, 3'b000, 0, 1, 32'hB);
    vt[4]  = mk(3'b000, 3'b000, 3'b000, 0, 1, 32'h3);
    vt[5]  = mk(3'b111, 3'b000, 3'b010, 0, 1, 32'h5);
    vt[6]  = mk(3'b101, 3'b000, 3'b000, 0, 1, 32'hB);
    vt[7]  = mk(3'b101, 3'b000, 3'b000, 0, 1, 32'h3);
    vt[8]  = mk(3'b101, 3'b000, 3'b001, 0, 1, 32'h4);
    vt[9]  = mk(3'b100, 3'b000, 3'b000, 0, 1, 32'hB);
    vt[10] = mk(3'b100, 3'b000, 3'b000, 0, 1, 32'h3);
    vt[11] = mk(3'b100, 3'b000, 3'b100, 0, 1, 32'h6);
    vt[12] = mk(3'b000, 3'b000, 3'b000, 0, 1, 32'hB);
    vt[13] = mk(3'b000, 3'b000, 3'b000, 0, 1, 32'h3);
    vt[14] = mk(3'b001, 3'b000, 3'b001, 0, 1, 32'h4);
    vt[15] = mk(3'b011, 3'b000, 3'b001, 0, 1, 32'h4);
    vt[16] = mk(3'b011, 3'b000, 3'b001, 0, 1, 32'h4);
    vt[17] = mk(3'b010, 3'b000, 3'b000, 0, 1, 32'hB);
    vt[18] = mk(3'b010, 3'b000, 3'b000, 0, 1, 32'h3);
    vt[19] = mk(3'b010, 3'b000, 3'b010, 0, 1, 32'h5);
    vt[20] = mk(3'b000, 3'b000, 3'b000, 0, 1, 32'hB);
    vt[21] = mk(3'b000, 3'b000, 3'b000, 0, 1, 32'h3);
    m_waddr = {3{16'h0003}};
    m_wdata = {3{32'hA5A5_0001}};
    for (int i = 0; i < 22; i++) begin
      req = vt[i].req; m_wen = vt[i].wen;
      step();
      chk($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vt[i].e_gnt));
      chk($sformatf("vec%0d_bus", i), 64'({reg_wen, reg_waddr, reg_wdata}),
          64'({vt[i].e_wen, vt[i].e_addr, vt[i].e_data}));
      chk($sformatf("vec%0d_status", i), 64'(status), 64'(vt[i].e_status));
    end

    // Watchdog: silent owner 2 is released after TIMEOUT cycles and locked out
    do_reset();
    req = 3'b100;
    cnt = 0;
    for (int i = 0; i < TO + 100; i++) begin
      step();
      if (gnt == 3'b100) cnt++;
      else if (cnt > 0) break;
    end
    chk("timeout_grant_len", 64'(cnt), 64'(TO));
    chk("timeout_err", 64'(status[6:4]), 64'h4);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt != 3'b000) saw = 1;
    end
    chk("timeout_lockout", 64'(saw), 64'h0);
    req = 3'b000; step();
    req = 3'b100; step(); step();
    chk("timeout_regrant", 64'(gnt), 64'h4);
    req = 3'b000; step(); step();

    // Drops: ungranted master 2 strobing, saturation, then clear
    do_reset();
    m_wen = 3'b100; m_waddr = {16'h1234, 32'h0}; m_wdata = {32'hDEAD_BEEF, 64'h0};
    saw = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (reg_wen) saw = 1;
    end
    chk("drop_no_forward", 64'(saw), 64'h0);
    chk("drop_saturate", 64'(status[15:8]), 64'hFF);
    m_wen = '0; status_clr = 1'b1; step(); status_clr = 1'b0;
    chk("status_clear", 64'(status), 64'h3);

    // Reset in the middle of a block write from master 1
    do_reset();
    m_waddr = {16'h0, 16'h0040, 16'h0}; m_wdata = {32'h0, 32'h1111_2222, 32'h0};
    req = 3'b010; step();
    m_blk_wstart = 3'b010; step();
    chk("blk_wstart_fwd", 64'(blk_wstart), 64'h1);
    m_blk_wstart = '0; m_blk_wen = 3'b010; step(); step();
    chk("blk_wen_fwd", 64'(blk_wen), 64'h1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("blk_reset_bus", 64'({gnt, reg_wen, blk_wen, blk_wstart, reg_waddr, reg_wdata}), 64'h0);
    chk("blk_reset_status", 64'(status), 64'h3);
    step();
    chk("blk_abandoned", 64'(blk_wen), 64'h0);
    quiet_inputs(); step(); step(); step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      for (int b = 0; b < 3; b++) begin
        m_wen[b]        = ($urandom_range(0, 3) == 0);
        m_blk_wen[b]    = ($urandom_range(0, 5) == 0);
        m_blk_wstart[b] = ($urandom_range(0, 9) == 0);
      end
      m_waddr    = {16'($urandom), 16'($urandom), 16'($urandom)};
      m_wdata    = {32'($urandom), 32'($urandom), 32'($urandom)};
      status_clr = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 699) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
